soc_system_button_debounce: RTL
===============================

SOC_SYSTEM_BUTTON_DEBOUNCE -- requirements
Module: soc_system_button_debounce

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer depth; legal range >= 2.
REQ-002 Parameter DEBOUNCE_CYCLES, default 50000 (1 ms at 50 MHz): required stable-sample count; legal range >= 2.
REQ-003 Parameter ACTIVE_LOW, default 1: 1 = raw button reads 0 when pressed (board KEY style).
REQ-004 Parameter LONG_PRESS_CYCLES, default 50000000 (1 s at 50 MHz): hold time for the long-press pulse.
REQ-005 clk  input  1  single clock for all logic.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 button_in  input  1  raw, asynchronous, bouncing push-button level.
REQ-008 button_out  output  1  debounced level, 1 = pressed; drives the button PIO in_port.
REQ-009 press_pulse  output  1  one-cycle pulse on each committed press.
REQ-010 release_pulse  output  1  one-cycle pulse on each committed release.
REQ-011 long_press  output  1  one-cycle pulse after a sustained press (see Configuration).

Function
REQ-012 button_in SHALL pass through a SYNC_STAGES flop chain; the chain output is inverted when ACTIVE_LOW=1, giving pressed-high sample s.
REQ-013 FSM states SHALL be: RELEASED, CHECK_PRESS, PRESSED, CHECK_RELEASE.
REQ-014 RELEASED -> CHECK_PRESS when s=1, with the counter cleared; PRESSED -> CHECK_RELEASE when s=0, with the counter cleared.
REQ-015 In CHECK_* states, the counter SHALL increment each cycle that s differs from the committed level; any cycle with s equal to the committed level SHALL return to the committed state and clear the counter (bounce restart).
REQ-016 When the counter reaches DEBOUNCE_CYCLES-1 with s still differing, the next edge SHALL commit: CHECK_PRESS -> PRESSED, CHECK_RELEASE -> RELEASED.
REQ-017 Latency: with button_in held at its new level, button_out SHALL change on edge SYNC_STAGES+DEBOUNCE_CYCLES-1, counting the first edge that samples the new level as edge 0.
REQ-018 button_out, press_pulse and release_pulse SHALL be registered; each pulse is high for exactly the single cycle in which button_out changes.
REQ-019 The debounce counter SHALL be $clog2(DEBOUNCE_CYCLES) bits wide and SHALL never wrap; a restart clears it.
REQ-020 A level change SHALL NOT commit on fewer than DEBOUNCE_CYCLES consecutive differing samples.

Reset
REQ-021 Reset SHALL force: state RELEASED, counters 0, button_out 0, press_pulse 0, release_pulse 0, long_press 0.
REQ-022 Synchronizer flops SHALL reset to the released raw level (1 if ACTIVE_LOW=1, else 0), so no spurious press follows reset release.
REQ-023 Reset asserted mid-CHECK SHALL abandon the count; after release the full REQ-017 latency applies again.

Configuration
REQ-024 Macro SOC_BUTTON_LONG_PRESS_EN defined: a saturating counter of $clog2(LONG_PRESS_CYCLES+1) bits SHALL run while in PRESSED; long_press SHALL pulse once, when the count reaches LONG_PRESS_CYCLES; it SHALL NOT repeat until a release commits; the counter SHALL clear on leaving PRESSED.
REQ-025 Macro undefined: the long-press logic SHALL be absent, the long_press port SHALL remain present, and long_press SHALL be tied to 0.

Structure
REQ-026 Package soc_system_button_pkg SHALL hold the FSM state typedef and the default constants for SYNC_STAGES, DEBOUNCE_CYCLES and LONG_PRESS_CYCLES.
REQ-027 The synchronizer SHALL be the sub-module soc_system_button_sync (parameterised depth, async reset, parameterised reset value).

Verification (DEBOUNCE_CYCLES=8, SYNC_STAGES=2, LONG_PRESS_CYCLES=32, ACTIVE_LOW=1)
REQ-028 Hold reset high with button_in=1, then release -> all outputs 0, and no pulse within 20 cycles.
REQ-029 Step button_in 1->0 and hold -> button_out rises and press_pulse is high for 1 cycle, both at edge 9.
REQ-030 Drive button_in 0 for 5 cycles, 1 for 1 cycle, then 0 held -> no early commit; button_out rises at edge 9 measured from the final 1->0 transition.
REQ-031 From PRESSED, step button_in 0->1 -> button_out falls and release_pulse is high for 1 cycle, both at edge 9.
REQ-032 With SOC_BUTTON_LONG_PRESS_EN defined, hold pressed -> long_press pulses once, 32 cycles after button_out rises, and does not repeat over a further 100 cycles; with the macro undefined, long_press stays 0.
REQ-033 Assert reset when the CHECK_PRESS count is 5 with the input held pressed -> outputs 0; after reset release, button_out rises at edge 9 after the reset release.

Source files
------------

// File: rtl/soc_system_button_pkg.sv
// -----------------------------------------------------------------------------
// soc_system_button_pkg
// Shared definitions for the push-button debouncer: FSM state encoding and the
// default timing constants (50 MHz board clock).
// -----------------------------------------------------------------------------
package soc_system_button_pkg;

    // Default synchronizer depth.
    localparam int DEF_SYNC_STAGES       = 2;
    // 1 ms of stable samples at 50 MHz.
    localparam int DEF_DEBOUNCE_CYCLES   = 50000;
    // 1 s hold time at 50 MHz.
    localparam int DEF_LONG_PRESS_CYCLES = 50000000;

    typedef enum logic [1:0] {
        RELEASED      = 2'd0,
        CHECK_PRESS   = 2'd1,
        PRESSED       = 2'd2,
        CHECK_RELEASE = 2'd3
    } btn_state_e;

endpackage : soc_system_button_pkg

// File: rtl/soc_system_button_sync.sv
// -----------------------------------------------------------------------------
// soc_system_button_sync
// Multi-flop synchronizer for a single asynchronous level.
//   clk    : destination clock
//   reset  : asynchronous, active-high; loads RESET_VAL into every stage
//   d_i    : asynchronous input level
//   q_o    : synchronized level (STAGES cycles of latency)
// -----------------------------------------------------------------------------
module soc_system_button_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : soc_system_button_sync

// File: rtl/soc_system_button_debounce.sv
// -----------------------------------------------------------------------------
// soc_system_button_debounce
// Synchronizes and debounces a raw push-button and produces a clean level plus
// press/release strobes and an optional long-press strobe.
//   clk           : single clock
//   reset         : asynchronous, active-high
//   button_in     : raw bouncing button level (active low when ACTIVE_LOW=1)
//   button_out    : debounced level, 1 = pressed
//   press_pulse   : one-cycle strobe in the cycle button_out rises
//   release_pulse : one-cycle strobe in the cycle button_out falls
//   long_press    : one-cycle strobe after LONG_PRESS_CYCLES of committed press
// Build option: define SOC_BUTTON_LONG_PRESS_EN to include the long-press
// detector; otherwise long_press is tied low.
// -----------------------------------------------------------------------------
module soc_system_button_debounce
    import soc_system_button_pkg::*;
#(
    parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW        = 1'b1,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic button_out,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic       sync_raw;
    logic       s;

    btn_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic       button_q, button_d;
    logic       press_q, press_d;
    logic       release_q, release_d;

    // Synchronizer resets to the idle raw level so reset release never looks
    // like a press.
    soc_system_button_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (ACTIVE_LOW ? 1'b1 : 1'b0)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (button_in),
        .q_o   (sync_raw)
    );

    assign s = ACTIVE_LOW ? ~sync_raw : sync_raw;

    // The sample that moves us into a CHECK state counts as the first stable
    // sample (cnt=0), so the commit happens on the edge that takes sample
    // number DEBOUNCE_CYCLES, i.e. when the incremented count reaches
    // DEBOUNCE_CYCLES-1. The count therefore never exceeds CNT_LAST.
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        button_d  = button_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            RELEASED: begin
                cnt_d = '0;
                if (s) state_d = CHECK_PRESS;
            end
            CHECK_PRESS: begin
                if (!s) begin
                    state_d = RELEASED;      // bounce: restart
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_LAST) begin
                    state_d  = PRESSED;
                    cnt_d    = '0;
                    button_d = 1'b1;
                    press_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            PRESSED: begin
                cnt_d = '0;
                if (!s) state_d = CHECK_RELEASE;
            end
            CHECK_RELEASE: begin
                if (s) begin
                    state_d = PRESSED;       // bounce: restart
                    cnt_d   = '0;
                end else if (cnt_inc == CNT_LAST) begin
                    state_d   = RELEASED;
                    cnt_d     = '0;
                    button_d  = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d  = RELEASED;
                cnt_d    = '0;
                button_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            button_q  <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            button_q  <= button_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign button_out    = button_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;

`ifdef SOC_BUTTON_LONG_PRESS_EN
    localparam int              LP_W   = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [LP_W-1:0] LP_MAX = LP_W'(LONG_PRESS_CYCLES);

    logic [LP_W-1:0] lp_cnt_q, lp_cnt_d;
    logic            lp_fired_q, lp_fired_d;
    logic            long_q, long_d;

    // lp_fired keeps a short bounce through CHECK_RELEASE (which clears the
    // counter) from producing a second strobe; only a committed release
    // re-arms the detector.
    always_comb begin
        lp_cnt_d   = lp_cnt_q;
        lp_fired_d = lp_fired_q;
        long_d     = 1'b0;
        if (state_q == PRESSED) begin
            if (lp_cnt_q != LP_MAX) lp_cnt_d = lp_cnt_q + 1'b1;
        end else begin
            lp_cnt_d = '0;
        end
        if ((lp_cnt_d == LP_MAX) && (lp_cnt_q != LP_MAX) && !lp_fired_q) begin
            long_d     = 1'b1;
            lp_fired_d = 1'b1;
        end
        if (release_d) lp_fired_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lp_cnt_q   <= '0;
            lp_fired_q <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            lp_cnt_q   <= lp_cnt_d;
            lp_fired_q <= lp_fired_d;
            long_q     <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif

endmodule : soc_system_button_debounce
